// File: rtl/data_packet_multiplexer.sv
// Packet-atomic round-robin merge of NUM_STREAMS input streams into one registered output,
// with a per-packet source index emitted on a separate select stream.
module data_packet_multiplexer #(
  parameter  int unsigned NUM_STREAMS  = 4,
  parameter  int unsigned DATA_W       = 8,
  parameter  int unsigned NUM_ELEMENTS = 2,
  localparam int unsigned SEL_W        = (NUM_STREAMS > 1) ? $clog2(NUM_STREAMS) : 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic [NUM_STREAMS-1:0]                              in_valid,
  output logic [NUM_STREAMS-1:0]                              in_ready,
  input  logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0][DATA_W-1:0] in_data,
  input  logic [NUM_STREAMS-1:0][NUM_ELEMENTS-1:0]            in_keep,
  input  logic [NUM_STREAMS-1:0]                              in_last,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [NUM_ELEMENTS-1:0][DATA_W-1:0]                 out_data,
  output logic [NUM_ELEMENTS-1:0]                             out_keep,
  output logic                                                out_last,
  output logic                                                select_valid,
  input  logic                                                select_ready,
  output logic [SEL_W-1:0]                                    select_data
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_next;
  logic [SEL_W-1:0] rr_ptr, rr_ptr_next;
  logic [SEL_W-1:0] gnt, gnt_next;
  logic [SEL_W-1:0] winner;
  logic             winner_found;
  logic             grant;
  logic             accept;

  // First valid input searching upward from rr_ptr with wrap-around
  always_comb begin
    winner       = '0;
    winner_found = 1'b0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      logic [SEL_W-1:0] idx;
      idx = SEL_W'((32'(rr_ptr) + k) % NUM_STREAMS);
      if (!winner_found && in_valid[idx]) begin
        winner_found = 1'b1;
        winner       = idx;
      end
    end
  end

  always_comb begin
    state_next  = state;
    rr_ptr_next = rr_ptr;
    gnt_next    = gnt;
    in_ready    = '0;
    grant       = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        // A new grant needs room for its index in the select slot
        if (winner_found && (!select_valid || select_ready)) begin
          grant      = 1'b1;
          gnt_next   = winner;
          state_next = LOCKED;
        end
      end
      LOCKED: begin
        in_ready[gnt] = !out_valid || out_ready;
        accept        = in_valid[gnt] && in_ready[gnt];
        if (accept && in_last[gnt]) begin
          state_next  = IDLE;
          rr_ptr_next = (32'(gnt) == NUM_STREAMS - 1) ? '0 : gnt + SEL_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rr_ptr <= '0;
      gnt    <= '0;
    end else begin
      state  <= state_next;
      rr_ptr <= rr_ptr_next;
      gnt    <= gnt_next;
    end
  end

  // Single output register slice; payload only moves on an accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_keep  <= '0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data[gnt];
      out_keep  <= in_keep[gnt];
      out_last  <= in_last[gnt];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Select slot: a grant reloads it even in the cycle the old index is consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      select_valid <= 1'b0;
      select_data  <= '0;
    end else if (grant) begin
      select_valid <= 1'b1;
      select_data  <= winner;
    end else if (select_ready) begin
      select_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_packet_multiplexer.sv
// Bench for data_packet_multiplexer: directed scenarios driven by randomized packet sources,
// scored against per-source expected beat queues and round-robin grant expectations.
module tb_data_packet_multiplexer;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned NE = 2;

  typedef struct packed {
    logic [NE-1:0][DW-1:0] data;
    logic [NE-1:0]         keep;
    logic                  last;
  } beat_t;

  logic                           clk;
  logic                           rst_n;
  logic [NS-1:0]                  in_valid;
  logic [NS-1:0]                  in_ready;
  logic [NS-1:0][NE-1:0][DW-1:0]  in_data;
  logic [NS-1:0][NE-1:0]          in_keep;
  logic [NS-1:0]                  in_last;
  logic                           out_valid;
  logic                           out_ready;
  logic [NE-1:0][DW-1:0]          out_data;
  logic [NE-1:0]                  out_keep;
  logic                           out_last;
  logic                           select_valid;
  logic                           select_ready;
  logic [1:0]                     select_data;

  data_packet_multiplexer #(.NUM_STREAMS(NS), .DATA_W(DW), .NUM_ELEMENTS(NE)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_keep(in_keep),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last),
    .select_valid(select_valid), .select_ready(select_ready), .select_data(select_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  beat_t       src_q[NS][$];
  beat_t       exp_q[NS][$];
  int unsigned pkt_src_q[$];
  int unsigned sel_q[$];
  int unsigned sel_log[$];
  int unsigned sel_cyc_log[$];
  int unsigned out_cyc_log[$];
  int unsigned vprob, oprob, sprob;
  bit [NS-1:0] en;
  int unsigned cyc = 0;
  int unsigned t0;
  bit          prev_stall;
  beat_t       prev_beat;
  bit          mid_pkt;
  int unsigned cur_src;
  bit          gap_chk;
  bit          have_prev;
  int unsigned prev_out_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic gen_pkt(input int unsigned s, input int unsigned len);
    for (int unsigned b = 0; b < len; b++) begin
      beat_t bt;
      bt.data[0] = {6'($urandom), 2'(s)};
      bt.data[1] = 8'($urandom);
      bt.keep    = 2'($urandom);
      bt.last    = (b == len - 1);
      src_q[s].push_back(bt);
      exp_q[s].push_back(bt);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (en[i] && src_q[i].size() > 0 && $urandom_range(99) < vprob) begin
        in_valid[i] = 1'b1;
        in_data[i]  = src_q[i][0].data;
        in_keep[i]  = src_q[i][0].keep;
        in_last[i]  = src_q[i][0].last;
      end else begin
        in_valid[i] = 1'b0;
        in_data[i]  = '0;
        in_keep[i]  = '0;
        in_last[i]  = 1'b0;
      end
    end
    out_ready    = ($urandom_range(99) < oprob);
    select_ready = ($urandom_range(99) < sprob);
  endtask

  // One clock: drive, observe handshakes just before the edge, then retire fired beats
  task automatic cycle();
    logic [NS-1:0] fired;
    beat_t         ob;
    int unsigned   s;
    drive();
    @(negedge clk);
    chk("ready_onehot", 64'($countones(in_ready) <= 1), 64'(1));
    if (out_valid && !out_ready) chk("ready_in_stall", 64'(in_ready), 64'(0));
    if (prev_stall) begin
      chk("stall_valid", 64'(out_valid), 64'(1));
      chk("stall_payload", 64'({out_data, out_keep, out_last}), 64'(prev_beat));
    end
    if (out_valid && out_ready) begin
      ob = {out_data, out_keep, out_last};
      s  = 32'(out_data[0][1:0]);
      out_cyc_log.push_back(cyc);
      chk("beat_pending", 64'(exp_q[s].size() > 0), 64'(1));
      if (exp_q[s].size() > 0) chk("beat", 64'(ob), 64'(exp_q[s].pop_front()));
      if (mid_pkt) chk("atomic_src", 64'(s), 64'(cur_src));
      else begin
        pkt_src_q.push_back(s);
        cur_src = s;
      end
      if (gap_chk && have_prev) chk("out_gap", 64'(cyc - prev_out_cyc), mid_pkt ? 64'(1) : 64'(2));
      mid_pkt      = !out_last;
      have_prev    = 1'b1;
      prev_out_cyc = cyc;
    end
    if (select_valid && select_ready) begin
      sel_q.push_back(32'(select_data));
      sel_log.push_back(32'(select_data));
      sel_cyc_log.push_back(cyc);
    end
    while (sel_q.size() > 0 && pkt_src_q.size() > 0)
      chk("select_vs_packet", 64'(sel_q.pop_front()), 64'(pkt_src_q.pop_front()));
    prev_stall = out_valid && !out_ready;
    prev_beat  = {out_data, out_keep, out_last};
    fired      = in_valid & in_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) if (fired[i]) void'(src_q[i].pop_front());
    cyc++;
  endtask

  function automatic bit all_done();
    bit d;
    d = !select_valid && !out_valid && !mid_pkt && sel_q.size() == 0 && pkt_src_q.size() == 0;
    for (int i = 0; i < NS; i++) d &= (src_q[i].size() == 0) && (exp_q[i].size() == 0);
    return d;
  endfunction

  task automatic run_until_done(input string tag, input int unsigned max_cyc);
    int unsigned n = 0;
    while (!all_done() && n < max_cyc) begin
      cycle();
      n++;
    end
    chk({tag, "_done"}, 64'(all_done()), 64'(1));
  endtask

  task automatic start_test(input bit [NS-1:0] mask, input int unsigned vp, input int unsigned op,
                            input int unsigned sp, input bit gc);
    en = mask; vprob = vp; oprob = op; sprob = sp; gap_chk = gc;
    sel_log.delete(); sel_cyc_log.delete(); out_cyc_log.delete();
    have_prev = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '1; in_data = '0; in_keep = '0; in_last = '0;
    out_ready = 1'b1; select_ready = 1'b1;
    prev_stall = 1'b0; mid_pkt = 1'b0; prev_beat = '0; cur_src = 0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_select_valid", 64'(select_valid), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    #20;
    in_valid = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All inputs continuously valid: strict rotation, one bubble between packets
    start_test(4'b1111, 100, 100, 100, 1'b1);
    for (int r = 0; r < 2; r++) for (int s = 0; s < NS; s++) gen_pkt(s, 2);
    run_until_done("rotation", 200);
    chk("rotation_count", 64'(sel_log.size()), 64'(8));
    for (int k = 0; k < sel_log.size(); k++) chk("rotation_idx", 64'(sel_log[k]), 64'(k % NS));

    // Select slot held busy: only one grant until the index is consumed
    start_test(4'b1001, 100, 100, 0, 1'b0);
    gen_pkt(0, 3);
    gen_pkt(3, 2);
    repeat (15) cycle();
    chk("held_no_sel_fire", 64'(sel_log.size()), 64'(0));
    chk("held_sel_valid", 64'(select_valid), 64'(1));
    chk("held_sel_data", 64'(select_data), 64'(0));
    chk("held_pkt0_drained", 64'(out_cyc_log.size()), 64'(3));
    chk("held_pkt3_waits", 64'(exp_q[3].size()), 64'(2));
    sprob = 100;
    run_until_done("held", 100);
    chk("held_sel_count", 64'(sel_log.size()), 64'(2));
    chk("held_sel_second", 64'(sel_log[1]), 64'(3));

    // Lone input 2, 3-beat packet: select one cycle after valid, back-to-back beats
    start_test(4'b0100, 100, 100, 100, 1'b0);
    gen_pkt(2, 3);
    run_until_done("single_src", 50);
    chk("single_sel_idx", 64'(sel_log[0]), 64'(2));
    chk("single_sel_cyc", 64'(sel_cyc_log[0] - t0), 64'(1));
    chk("single_beats", 64'(out_cyc_log.size()), 64'(3));
    for (int k = 0; k < 3; k++) chk("single_out_cyc", 64'(out_cyc_log[k] - t0), 64'(k + 2));

    // Pointer at 3 with inputs 1 and 2 pending: search wraps to 1 first
    start_test(4'b0110, 100, 100, 100, 1'b0);
    gen_pkt(1, 2);
    gen_pkt(2, 2);
    run_until_done("wrap", 100);
    chk("wrap_first", 64'(sel_log[0]), 64'(1));
    chk("wrap_second", 64'(sel_log[1]), 64'(2));

    // Random output back-pressure on a packet from input 1
    start_test(4'b0010, 100, 50, 100, 1'b0);
    gen_pkt(1, 6);
    run_until_done("backpressure", 300);
    chk("bp_beats", 64'(out_cyc_log.size()), 64'(6));

    // Asynchronous reset in the middle of a packet from input 2 (pointer currently 2)
    start_test(4'b0100, 100, 100, 0, 1'b0);
    gen_pkt(2, 8);
    repeat (4) cycle();
    chk("pre_rst_out_valid", 64'(out_valid), 64'(1));
    chk("pre_rst_sel_valid", 64'(select_valid), 64'(1));
    chk("pre_rst_in_ready", 64'(in_ready), 64'(4'b0100));
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_sel_valid", 64'(select_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
    sel_q.delete(); pkt_src_q.delete();
    mid_pkt = 1'b0; prev_stall = 1'b0;
    in_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    start_test(4'b1010, 100, 100, 100, 1'b0);
    gen_pkt(1, 2);
    gen_pkt(3, 2);
    run_until_done("post_rst", 100);
    chk("post_rst_first", 64'(sel_log[0]), 64'(1));
    chk("post_rst_second", 64'(sel_log[1]), 64'(3));

    // Random soak: all sources, gaps, stalls and 1..4-beat packets
    start_test(4'b1111, 70, 70, 60, 1'b0);
    for (int p = 0; p < 24; p++) gen_pkt($urandom_range(NS - 1), $urandom_range(4, 1));
    run_until_done("soak", 3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
